// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: round-robin grant over BCP engines, duplicate/conflict
// filtering against queued literals, and a FIFO feeding the global state table.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif

module uc_arbiter #(
    parameter int NUM_ENGINE = `NUM_ENGINE,
    parameter int LIT_W      = 8,
    parameter int UC_DEPTH   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_ENGINE-1:0][LIT_W-1:0]     eng2ucarb_lit,
    input  logic [NUM_ENGINE-1:0]                eng2ucarb_valid,
    output logic [NUM_ENGINE-1:0]                ucarb2eng_ack,
    output logic signed [LIT_W-1:0]              ucarb2gst_lit,
    output logic                                 ucarb2gst_empty,
    input  logic                                 gst2ucarb_pop,
    output logic                                 ucarb_conflict,
    input  logic                                 ctrl2ucarb_clear,
    output logic [$clog2(UC_DEPTH):0]            ucarb_count
);
    localparam int PTR_W = $clog2(UC_DEPTH);
    localparam int ENG_W = $clog2(NUM_ENGINE);
    localparam int CNT_W = PTR_W + 1;

    logic [ENG_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        count;
    logic signed [LIT_W-1:0] mem [UC_DEPTH];

    logic                    gnt_found_p0;
    logic [ENG_W-1:0]        gnt_idx_p0;
    logic                    gnt_vld_p0;
    logic signed [LIT_W-1:0] gnt_lit_p0;
    logic                    dup_p0;
    logic                    opp_p0;
    logic                    push_p0;
    logic                    pop_p0;
    logic                    set_conf_p0;

    function automatic logic signed [LIT_W-1:0] neg_lit(input logic signed [LIT_W-1:0] l);
        return -l;
    endfunction

    // Stage p0: round-robin search starting at rr_ptr, then match against queued entries
    always_comb begin
        int k;
        k            = 0;
        gnt_found_p0 = 1'b0;
        gnt_idx_p0   = '0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NUM_ENGINE) k = k - NUM_ENGINE;
            if (!gnt_found_p0 && eng2ucarb_valid[ENG_W'(k)]) begin
                gnt_found_p0 = 1'b1;
                gnt_idx_p0   = ENG_W'(k);
            end
        end
    end

    assign gnt_lit_p0 = $signed(eng2ucarb_lit[gnt_idx_p0]);
    assign gnt_vld_p0 = gnt_found_p0 && (count != CNT_W'(UC_DEPTH)) && !ucarb_conflict
                        && !rst && !ctrl2ucarb_clear;

    always_comb begin
        ucarb2eng_ack = '0;
        if (gnt_vld_p0) ucarb2eng_ack[gnt_idx_p0] = 1'b1;
    end

    // The entry being popped this cycle still counts as present for matching.
    always_comb begin
        logic [PTR_W-1:0] slot;
        slot   = '0;
        dup_p0 = 1'b0;
        opp_p0 = 1'b0;
        for (int j = 0; j < UC_DEPTH; j++) begin
            slot = rd_ptr + PTR_W'(j);
            if (CNT_W'(j) < count) begin
                if (mem[slot] == gnt_lit_p0)          dup_p0 = 1'b1;
                if (mem[slot] == neg_lit(gnt_lit_p0)) opp_p0 = 1'b1;
            end
        end
    end

    assign push_p0     = gnt_vld_p0 && (gnt_lit_p0 != '0) && !dup_p0 && !opp_p0;
    assign set_conf_p0 = gnt_vld_p0 && (gnt_lit_p0 != '0) && !dup_p0 && opp_p0;
    assign pop_p0      = gst2ucarb_pop && (count != '0);

    // Stage p1: control state update; clear and reset share the same next state
    always_ff @(posedge clk) begin
        if (rst || ctrl2ucarb_clear) begin
            rr_ptr         <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            ucarb_conflict <= 1'b0;
        end else begin
            if (gnt_vld_p0)
                rr_ptr <= (gnt_idx_p0 == ENG_W'(NUM_ENGINE - 1)) ? '0 : gnt_idx_p0 + 1'b1;
            if (push_p0) wr_ptr <= wr_ptr + 1'b1;
            if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_p0, pop_p0})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (set_conf_p0) ucarb_conflict <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_p0) mem[wr_ptr] <= gnt_lit_p0;
    end

    assign ucarb2gst_empty = (count == '0);
    assign ucarb2gst_lit   = ucarb2gst_empty ? '0 : mem[rd_ptr];
    assign ucarb_count     = count;

endmodule

// File: tb/tb_uc_arbiter.sv
// Scoreboard bench for uc_arbiter: queue-based reference model predicts acks and
// FIFO outputs per cycle; a negedge monitor pops expectations and compares.
module tb_uc_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    pop = 1'b0;
    logic                    clr = 1'b0;
    logic [N-1:0][W-1:0]     lit_in = '0;
    logic [N-1:0]            vld_in = '0;
    logic [N-1:0]            ack;
    logic signed [W-1:0]     head;
    logic                    empty;
    logic                    conf;
    logic [$clog2(D):0]      cnt;

    always #5 clk = ~clk;

    uc_arbiter #(.NUM_ENGINE(N), .LIT_W(W), .UC_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .eng2ucarb_lit(lit_in), .eng2ucarb_valid(vld_in), .ucarb2eng_ack(ack),
        .ucarb2gst_lit(head), .ucarb2gst_empty(empty), .gst2ucarb_pop(pop),
        .ucarb_conflict(conf), .ctrl2ucarb_clear(clr), .ucarb_count(cnt)
    );

    typedef struct {
        logic [N-1:0] ack;
        bit           empty;
        int           head;
        int           count;
        bit           conf;
    } exp_t;

    exp_t exp_q[$];
    int   mq[$];
    int   rr = 0;
    bit   mconf = 1'b0;
    int   req_l[N];
    bit   req_v[N];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic req(int e, int v);
        req_v[e] = 1'b1;
        req_l[e] = v;
    endtask

    // One cycle: drive inputs, predict outputs from the model, advance the model.
    task automatic step(bit r, bit c, bit p);
        exp_t         e;
        logic [N-1:0] a;
        int           g;
        int           l;
        bit           dup;
        bit           opp;
        rst = r; clr = c; pop = p;
        for (int i = 0; i < N; i++) begin
            vld_in[i] = req_v[i];
            lit_in[i] = W'(req_l[i]);
        end
        g = -1; l = 0; dup = 1'b0; opp = 1'b0;
        if (!r && !c && mq.size() < D && !mconf)
            for (int i = 0; i < N; i++)
                if (g < 0 && req_v[(rr + i) % N]) g = (rr + i) % N;
        a = (g >= 0) ? (N'(1) << g) : '0;
        e.ack   = a;
        e.empty = (mq.size() == 0);
        e.head  = (mq.size() > 0) ? mq[0] : 0;
        e.count = mq.size();
        e.conf  = mconf;
        exp_q.push_back(e);
        if (r || c) begin
            mq.delete();
            rr    = 0;
            mconf = 1'b0;
        end else begin
            if (g >= 0) begin
                l = req_l[g];
                foreach (mq[k]) begin
                    if (mq[k] == l)  dup = 1'b1;
                    if (mq[k] == -l) opp = 1'b1;
                end
            end
            if (p && mq.size() > 0) void'(mq.pop_front());
            if (g >= 0) begin
                rr       = (g + 1) % N;
                req_v[g] = 1'b0;
                if (l != 0 && !dup) begin
                    if (opp) mconf = 1'b1;
                    else     mq.push_back(l);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ack",      int'(ack),   int'(e.ack));
            chk("empty",    int'(empty), int'(e.empty));
            chk("head",     int'(head),  e.head);
            chk("count",    int'(cnt),   e.count);
            chk("conflict", int'(conf),  int'(e.conf));
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin req_v[i] = 1'b0; req_l[i] = 0; end
        @(posedge clk); #1;
        step(1, 0, 0);
        step(1, 0, 0);
        // single request, then three simultaneous requests from rr_ptr=0
        req(0, 3); step(0, 0, 0); step(0, 0, 0);
        step(0, 1, 0);
        req(0, 3); req(1, 4); req(2, 5);
        repeat (3) step(0, 0, 0);
        repeat (4) step(0, 0, 1);
        // duplicate and conflict, then recovery through clear
        step(0, 1, 0);
        req(0, 4);  step(0, 0, 0);
        req(1, 4);  step(0, 0, 0);
        req(2, -4); step(0, 0, 0);
        req(3, 7);  step(0, 0, 0); step(0, 0, 0);
        step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
        // fill to capacity; pop does not free space for a same-cycle push
        step(0, 1, 0);
        for (int k = 1; k <= D; k++) begin req(0, k); step(0, 0, 0); end
        req(1, 9); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
        repeat (D + 3) step(0, 0, 1);
        // null literal, push+pop at count 1
        req(0, 0);  step(0, 0, 0);
        req(0, 6);  step(0, 0, 0);
        req(1, 11); step(0, 0, 1); step(0, 0, 0);
        // reset mid-operation with a request pending
        step(0, 1, 0);
        req(0, 21); req(1, 22); req(2, 23);
        repeat (3) step(0, 0, 0);
        req(3, 24); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        // randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++)
                if (!req_v[i] && $urandom_range(0, 99) < 40) req(i, int'($urandom_range(0, 24)) - 12);
            step($urandom_range(0, 199) == 0,
                 ($urandom_range(0, 49) == 0) || (mconf && $urandom_range(0, 9) == 0),
                 $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < N; i++) req_v[i] = 1'b0;
        step(0, 0, 0); step(0, 0, 0);
        @(negedge clk); #1;
        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
